// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point divider constants, arbiter state and flag bit positions
package fxp_pkg;

  localparam int FXP_N = 32;
  localparam int FXP_R = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int FLG_VALID = 0;
  localparam int FLG_DBZ   = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_TMO   = 3;

endpackage

// File: rtl/fxp_div_arbiter_if.sv
// rtl/fxp_div_arbiter_if.sv - request and response channels of the shared-divider arbiter
interface fxp_div_arbiter_if
  import fxp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = FXP_N
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_val;
  logic [3:0]            rsp_flags;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_val, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_val, rsp_flags
  );

endinterface

// File: rtl/fxp_div_arbiter_rr_arbiter.sv
// rtl/fxp_div_arbiter_rr_arbiter.sv - combinational round-robin grant search starting at a pointer
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    // Lowest priority first, so the hit nearest the pointer is the one left standing.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fxp_div_arbiter.sv
// rtl/fxp_div_arbiter.sv - round-robin sequencer sharing one fxp_div between NREQ requesters
// Optional WAIT watchdog with divider abort: FXP_DIV_ARB_TIMEOUT_EN
module fxp_div_arbiter
  import fxp_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int WIDTH          = FXP_N,
  parameter int FBITS          = FXP_R,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  fxp_div_arbiter_if.slave bus,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val
`ifdef FXP_DIV_ARB_TIMEOUT_EN
  ,
  output logic             div_rst_o
`endif
);
  localparam int IDW = $clog2(NREQ);

  if (FBITS < 0 || FBITS >= WIDTH) begin : g_fbits_check
    $error("fxp_div_arbiter: FBITS must lie in [0, WIDTH)");
  end

  arb_state_e      state;
  logic [IDW-1:0]  ptr, gidx, id_q, rsp_id_q;
  logic [NREQ-1:0] grant;
  logic            any, accept;
  logic [WIDTH-1:0] a_q, b_q, val_q;
  logic [3:0]      flags_q;
  logic            start_q, rsp_valid_q;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign accept        = (state == IDLE) && !div_busy && any;
  assign bus.req_ready = (accept && !rst) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_val   = val_q;
  assign bus.rsp_flags = flags_q;
  assign div_start     = start_q;
  assign div_a         = a_q;
  assign div_b         = b_q;

`ifdef FXP_DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          abort_q;
  logic          timed_out;
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign div_rst_o = rst | abort_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      val_q       <= '0;
      flags_q     <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef FXP_DIV_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef FXP_DIV_ARB_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.req_a[gidx*WIDTH +: WIDTH];
            b_q     <= bus.req_b[gidx*WIDTH +: WIDTH];
            id_q    <= gidx;
            ptr     <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FXP_DIV_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            val_q              <= div_val;
            flags_q            <= '0;
            flags_q[FLG_VALID] <= div_valid;
            flags_q[FLG_DBZ]   <= div_dbz;
            flags_q[FLG_OVF]   <= div_ovf;
            rsp_id_q           <= id_q;
            rsp_valid_q        <= 1'b1;
            state              <= RESP;
          end
`ifdef FXP_DIV_ARB_TIMEOUT_EN
          else if (timed_out) begin
            val_q            <= '0;
            flags_q          <= '0;
            flags_q[FLG_TMO] <= 1'b1;
            rsp_id_q         <= id_q;
            rsp_valid_q      <= 1'b1;
            abort_q          <= 1'b1;
            state            <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div_arbiter.sv
// tb/tb_fxp_div_arbiter.sv - scoreboard bench for fxp_div_arbiter with a behavioural divider stub
// Timeout scenario runs only when FXP_DIV_ARB_TIMEOUT_EN is defined
module tb_fxp_div_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int FB   = 16;
`ifdef FXP_DIV_ARB_TIMEOUT_EN
  localparam int TMO  = 8;
`else
  localparam int TMO  = 255;
`endif

  typedef struct packed {
    logic [W-1:0] val;
    logic [3:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic div_start, div_busy, div_done, div_valid, div_dbz, div_ovf;
  logic [W-1:0] div_a, div_b, div_val;
  logic stub_rst, stall, junk, rnd_bp;
  int   lat;
  logic [W-1:0] sa, sb;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  exp_t exp_q[NREQ][$];
  int   exp_id_q[$];

  fxp_div_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

`ifdef FXP_DIV_ARB_TIMEOUT_EN
  logic div_rst_o;
  assign stub_rst = rst | div_rst_o;
`else
  assign stub_rst = rst;
`endif

  fxp_div_arbiter #(.NREQ(NREQ), .WIDTH(W), .FBITS(FB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_valid (div_valid),
    .div_dbz   (div_dbz),
    .div_ovf   (div_ovf),
    .div_val   (div_val)
`ifdef FXP_DIV_ARB_TIMEOUT_EN
    ,
    .div_rst_o (div_rst_o)
`endif
  );

  always #5 clk = ~clk;

  // Q16.16 signed divide with saturation: returns {ovf, dbz, valid, quotient}
  function automatic logic [34:0] fxp_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint q;
    if (b == '0) return {3'b010, a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF};
    q = (longint'($signed(a)) * 65536) / longint'($signed(b));
    if ((q >>> 31) != 0 && (q >>> 31) != -1)
      return {3'b100, (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
    return {3'b001, q[31:0]};
  endfunction

  always @(posedge clk or posedge stub_rst) begin
    if (stub_rst) begin
      div_busy <= 1'b0; div_done <= 1'b0; div_val <= '0;
      div_valid <= 1'b0; div_dbz <= 1'b0; div_ovf <= 1'b0; lat <= 0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        div_busy <= 1'b1; sa <= div_a; sb <= div_b; lat <= $urandom_range(1, 6);
      end else if (div_busy) begin
        if (!stall) begin
          if (lat == 0) begin
            div_busy <= 1'b0; div_done <= 1'b1;
            {div_ovf, div_dbz, div_valid, div_val} <= fxp_ref(sa, sb);
          end else lat <= lat - 1;
        end
      end else if (junk && $urandom_range(0, 7) == 0) begin
        div_done <= 1'b1; div_val <= $urandom; div_valid <= 1'b1;
      end
    end
  end

  logic prev_start = 1'b0;
  logic hold_chk = 1'b0;
  logic [W+5:0] held;
  int waited[NREQ];
  logic [NREQ-1:0] hs_m;

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (!$onehot0(bus.req_ready) || ((bus.req_ready & ~bus.req_valid) != '0) ||
          (bus.req_ready != '0 && (div_busy || bus.rsp_valid || div_start))) begin
        bad++;
        $display("FAIL req_ready: got %b (valid=%b busy=%b rsp_valid=%b), required one-hot to a valid requester only when idle",
                 bus.req_ready, bus.req_valid, div_busy, bus.rsp_valid);
      end
      if (div_start) begin
        total++;
        if (prev_start) begin
          bad++; $display("FAIL start_width: div_start high 2+ cycles, required 1");
        end else n_start++;
      end
      prev_start = div_start;
      if (hold_chk) begin
        total++;
        if (!bus.rsp_valid || {bus.rsp_id, bus.rsp_val, bus.rsp_flags} != held) begin
          bad++;
          $display("FAIL rsp_stable: got valid=%b %h, required valid=1 %h", bus.rsp_valid,
                   {bus.rsp_id, bus.rsp_val, bus.rsp_flags}, held);
        end
      end
      hs_m = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_m[i]) begin
          total++;
          if (waited[i] > NREQ - 1) begin
            bad++; $display("FAIL fairness: req %0d waited %0d grants, required <= %0d", i, waited[i], NREQ - 1);
          end
          waited[i] = 0;
        end else if (hs_m != '0 && bus.req_valid[i]) waited[i]++;
        if (!bus.req_valid[i]) waited[i] = 0;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        total++;
        if (exp_id_q.size() > 0 && int'(bus.rsp_id) != exp_id_q[0]) begin
          bad++; $display("FAIL rsp_order: got id=%0d required id=%0d", bus.rsp_id, exp_id_q[0]);
        end else if (exp_q[bus.rsp_id].size() == 0) begin
          bad++; $display("FAIL rsp_unexpected: got id=%0d val=%h, required no response", bus.rsp_id, bus.rsp_val);
        end else if ({bus.rsp_val, bus.rsp_flags} != exp_q[bus.rsp_id][0]) begin
          bad++;
          $display("FAIL rsp_data id=%0d: got val=%h flags=%b required val=%h flags=%b", bus.rsp_id,
                   bus.rsp_val, bus.rsp_flags, exp_q[bus.rsp_id][0].val, exp_q[bus.rsp_id][0].flags);
        end
        if (exp_id_q.size() > 0) void'(exp_id_q.pop_front());
        if (exp_q[bus.rsp_id].size() > 0) void'(exp_q[bus.rsp_id].pop_front());
      end
      hold_chk = bus.rsp_valid && !bus.rsp_ready;
      held = {bus.rsp_id, bus.rsp_val, bus.rsp_flags};
    end else begin
      prev_start = 1'b0;
      hold_chk = 1'b0;
      for (int i = 0; i < NREQ; i++) waited[i] = 0;
    end
  end

  task automatic step();
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs;
    if (rnd_bp) bus.rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic issue_exp(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] val, input logic [3:0] fl);
    exp_t e;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_valid[i] = 1'b1;
    e.val = val; e.flags = fl;
    exp_q[i].push_back(e);
  endtask

  task automatic issue_rnd(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [34:0] r;
    r = fxp_ref(a, b);
    issue_exp(i, a, b, r[31:0], {1'b0, r[34:32]});
  endtask

  function automatic int pending();
    int s = exp_id_q.size();
    for (int i = 0; i < NREQ; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 3000) begin step(); n++; end
    total++;
    if (pending() != 0) begin
      bad++; $display("FAIL %s_drain: %0d responses outstanding after %0d cycles, required 0", tag, pending(), n);
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      exp_id_q.delete();
    end
    step();
  endtask

  task automatic check_reset(input string tag);
    total++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_val !== '0 ||
        bus.rsp_flags !== '0 || div_start !== 1'b0 || div_a !== '0 || div_b !== '0) begin
      bad++;
      $display("FAIL %s: ready=%b rsp_valid=%b id=%0d val=%h flags=%b start=%b a=%h b=%h, required all zero",
               tag, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_val, bus.rsp_flags, div_start, div_a, div_b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] a, b;
    int ns0, n, issued;
    rst = 1'b1; stall = 1'b0; junk = 1'b0; rnd_bp = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    bus.req_valid = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single request 20.0 / 5.0
    ns0 = n_start;
    issue_exp(0, 32'h0014_0000, 32'h0005_0000, 32'h0004_0000, 4'b0001);
    exp_id_q.push_back(0);
    drain("single");
    total++;
    if (n_start - ns0 != 1) begin
      bad++; $display("FAIL start_count: got %0d pulses, required 1", n_start - ns0);
    end

    // all four at once from reset: served 0,1,2,3
    do_reset();
    issue_exp(0, 32'h000A_0000, 32'h0002_0000, 32'h0005_0000, 4'b0001);
    issue_exp(1, 32'hFFEC_0000, 32'h0005_0000, 32'hFFFC_0000, 4'b0001);
    issue_exp(2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 4'b0001);
    issue_exp(3, 32'hFFF6_0000, 32'hFFFD_0000, 32'h0003_5555, 4'b0001);
    for (int i = 0; i < NREQ; i++) exp_id_q.push_back(i);
    drain("all_four");

    // divide by zero passes through, next request unaffected
    issue_exp(2, 32'h0014_0000, 32'h0000_0000, 32'h7FFF_FFFF, 4'b0010);
    exp_id_q.push_back(2);
    drain("dbz");
    issue_exp(2, 32'h0014_0000, 32'hFFFB_0000, 32'hFFFC_0000, 4'b0001);
    exp_id_q.push_back(2);
    drain("after_dbz");

    // response backpressure for 10 cycles
    bus.rsp_ready = 1'b0;
    issue_exp(1, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 4'b0001);
    exp_id_q.push_back(1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin step(); n++; end
    issue_exp(3, 32'h0007_8000, 32'h0002_8000, 32'h0003_0000, 4'b0001);
    exp_id_q.push_back(3);
    for (int k = 0; k < 10; k++) begin
      step();
      #3;
      total++;
      if (bus.req_ready !== '0 || div_start !== 1'b0 || bus.rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL backpressure cycle %0d: ready=%b start=%b rsp_valid=%b, required 0000/0/1",
                 k, bus.req_ready, div_start, bus.rsp_valid);
      end
    end
    bus.rsp_ready = 1'b1;
    drain("backpressure");

    // reset while the divider is working drops the request
    issue_exp(0, 32'h0003_0000, 32'h0001_0000, 32'h0003_0000, 4'b0001);
    n = 0;
    while (!div_start && n < 50) begin step(); n++; end
    step();
    rst = 1'b1;
    #1;
    check_reset("reset_in_wait");
    void'(exp_q[0].pop_back());
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue_exp(2, 32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 4'b0001);
    exp_id_q.push_back(2);
    drain("after_reset");

    // randomized traffic with backpressure, withdrawals and stray div_done pulses
    rnd_bp = 1'b1; junk = 1'b1; issued = 0; n = 0;
    while (issued < 300 && n < 40000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          a = $urandom;
          a = $signed(a) >>> $urandom_range(0, 24);
          b = $urandom;
          b = $signed(b) >>> $urandom_range(4, 30);
          if ($urandom_range(0, 9) == 0) b = '0;
          issue_rnd(i, a, b);
          issued++;
        end else if (bus.req_valid[i] && $urandom_range(0, 31) == 0) begin
          bus.req_valid[i] = 1'b0;
          void'(exp_q[i].pop_back());
        end
      end
      step();
      n++;
    end
    drain("random");
    rnd_bp = 1'b0; junk = 1'b0; bus.rsp_ready = 1'b1;
    step();

`ifdef FXP_DIV_ARB_TIMEOUT_EN
    stall = 1'b1;
    issue_exp(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1000);
    n = 0;
    while (!div_start && n < 50) begin step(); n++; end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin step(); n++; end
    total++;
    if (n != TMO + 1) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles after issue, required %0d", n, TMO + 1);
    end
    drain("timeout");
    stall = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
